// File: rtl/mmcm_ctrl_pkg.sv
// rtl/mmcm_ctrl_pkg.sv - state encoding and parameter defaults for the MMCM reset sequencer
package mmcm_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RST_HOLD  = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } seq_state_e;

   localparam int DEF_RST_HOLD_CYCLES    = 16;
   localparam int DEF_LOCK_TIMEOUT       = 24000;
   localparam int DEF_LOCK_STABLE_CYCLES = 256;
   localparam int DEF_MAX_RETRIES        = 3;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous level
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/mmcm_reset_sequencer.sv
// rtl/mmcm_reset_sequencer.sv - MMCM reset pulse, lock qualification with retry, core reset release
module mmcm_reset_sequencer
   import mmcm_ctrl_pkg::*;
#(
   parameter int RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
   parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
   parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int MAX_RETRIES        = DEF_MAX_RETRIES
) (
   input  logic       clk_in1,
   input  logic       reset,
   input  logic       restart,
   input  logic       mmcm_locked,
   output logic       mmcm_reset,
   output logic       core_reset,
   output logic       ready,
   output logic       error,
   output logic [3:0] retry_count,
   output logic [7:0] lock_loss_count,
   output logic [2:0] state
);

   localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
   localparam int TMR_W  = $clog2(LOCK_TIMEOUT + 1);
   localparam int STB_W  = $clog2(LOCK_STABLE_CYCLES + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
   // The locked cycle seen in WAIT_LOCK counts toward the stable run, so STABLE needs one fewer.
   localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 2);
   localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRIES);

   logic              locked_s;
   seq_state_e        state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [STB_W-1:0]  stb_q, stb_d;
   logic [3:0]        retry_q, retry_d;
   logic [7:0]        loss_q, loss_d;
   logic              timeout;
   logic              mmcm_reset_q, core_reset_q, ready_q, error_q;

   sync_2ff u_lock_sync (
      .clk_i (clk_in1),
      .rst_i (reset),
      .d_i   (mmcm_locked),
      .q_o   (locked_s)
   );

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      tmr_d   = tmr_q;
      stb_d   = stb_q;
      retry_d = retry_q;
      loss_d  = loss_q;
      timeout = 1'b0;

      case (state_q)
         ST_RST_HOLD: begin
            if (hold_q == HOLD_LAST) begin
               state_d = ST_WAIT_LOCK;
               tmr_d   = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_WAIT_LOCK: begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == TMR_LAST) begin
               timeout = 1'b1;
            end else if (locked_s) begin
               state_d = ST_STABLE;
               stb_d   = '0;
            end
         end
         ST_STABLE: begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == TMR_LAST) begin
               timeout = 1'b1;
            end else if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
            end else if (stb_q == STB_LAST) begin
               state_d = ST_RUN;
               retry_d = '0;
            end else begin
               stb_d = stb_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (!locked_s) begin
               state_d = ST_RST_HOLD;
               hold_d  = '0;
               if (loss_q != 8'hFF) begin
                  loss_d = loss_q + 8'd1;
               end
            end
         end
         ST_FAIL: begin
         end
         default: begin
            state_d = ST_RST_HOLD;
            hold_d  = '0;
         end
      endcase

      if (timeout) begin
         retry_d = retry_q + 4'd1;
         hold_d  = '0;
         state_d = (retry_d == RETRY_MAX) ? ST_FAIL : ST_RST_HOLD;
      end

      // A lock loss counted above survives the restart override.
      if (restart) begin
         state_d = ST_RST_HOLD;
         hold_d  = '0;
         retry_d = '0;
      end
   end

   always_ff @(posedge clk_in1) begin
      if (reset) begin
         state_q      <= ST_RST_HOLD;
         hold_q       <= '0;
         tmr_q        <= '0;
         stb_q        <= '0;
         retry_q      <= '0;
         loss_q       <= '0;
         mmcm_reset_q <= 1'b1;
         core_reset_q <= 1'b1;
         ready_q      <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         tmr_q        <= tmr_d;
         stb_q        <= stb_d;
         retry_q      <= retry_d;
         loss_q       <= loss_d;
         mmcm_reset_q <= (state_d == ST_RST_HOLD) || (state_d == ST_FAIL);
         core_reset_q <= (state_d != ST_RUN);
         ready_q      <= (state_d == ST_RUN);
         error_q      <= (state_d == ST_FAIL);
      end
   end

   assign mmcm_reset      = mmcm_reset_q;
   assign core_reset      = core_reset_q;
   assign ready           = ready_q;
   assign error           = error_q;
   assign retry_count     = retry_q;
   assign lock_loss_count = loss_q;
   assign state           = state_q;

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// tb/tb_mmcm_reset_sequencer.sv - bench for mmcm_reset_sequencer with a window-based reference model
module tb_mmcm_reset_sequencer;
   import mmcm_ctrl_pkg::*;

   localparam int HOLD = 4;
   localparam int TO   = 50;
   localparam int LSC  = 8;
   localparam int MR   = 2;
   localparam int MAXN = 8192;

   localparam int PH_HOLD   = 0;
   localparam int PH_SEARCH = 1;
   localparam int PH_RUN    = 2;
   localparam int PH_FAIL   = 3;

   logic       clk;
   logic       rst;
   logic       restart_r;
   logic       locked_r;
   logic       o_mrst, o_crst, o_rdy, o_err;
   logic [3:0] o_rt;
   logic [7:0] o_ll;
   logic [2:0] o_st;

   logic       lk [MAXN];
   logic       rs [MAXN];
   logic [2:0] ex_st [MAXN];
   logic [3:0] ex_rt [MAXN];
   logic [7:0] ex_ll [MAXN];
   logic [2:0] ob_st [MAXN];
   logic       ob_mrst [MAXN];
   logic       ob_crst [MAXN];
   logic       ob_rdy [MAXN];
   logic       ob_err [MAXN];
   logic [3:0] ob_rt [MAXN];
   logic [7:0] ob_ll [MAXN];

   int pass_cnt = 0;
   int total    = 0;
   int n;

   mmcm_reset_sequencer #(
      .RST_HOLD_CYCLES   (HOLD),
      .LOCK_TIMEOUT      (TO),
      .LOCK_STABLE_CYCLES(LSC),
      .MAX_RETRIES       (MR)
   ) dut (
      .clk_in1        (clk),
      .reset          (rst),
      .restart        (restart_r),
      .mmcm_locked    (locked_r),
      .mmcm_reset     (o_mrst),
      .core_reset     (o_crst),
      .ready          (o_rdy),
      .error          (o_err),
      .retry_count    (o_rt),
      .lock_loss_count(o_ll),
      .state          (o_st)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Synchronised lock as seen by the sequencer in cycle c.
   function automatic logic ls(input int c);
      if (c < 2) return 1'b0;
      return lk[c-2];
   endfunction

   function automatic logic [18:0] pack(input logic [2:0] st, input logic [3:0] rt, input logic [7:0] ll);
      return {st, (st == ST_RST_HOLD) || (st == ST_FAIL), st != ST_RUN, st == ST_RUN, st == ST_FAIL, rt, ll};
   endfunction

   task automatic build_model(input int len);
      int   start;
      int   retries;
      int   loss;
      int   ph;
      logic win;
      start = 0; retries = 0; loss = 0; ph = PH_HOLD;
      for (int k = 0; k < len; k++) begin
         case (ph)
            PH_HOLD:   ex_st[k] = ST_RST_HOLD;
            PH_SEARCH: ex_st[k] = (k > start && ls(k-1)) ? ST_STABLE : ST_WAIT_LOCK;
            PH_RUN:    ex_st[k] = ST_RUN;
            default:   ex_st[k] = ST_FAIL;
         endcase
         ex_rt[k] = 4'(retries);
         ex_ll[k] = 8'(loss);
         if (rs[k]) begin
            if (ph == PH_RUN && !ls(k) && loss < 255) loss++;
            retries = 0; ph = PH_HOLD; start = k + 1;
         end else if (ph == PH_HOLD) begin
            if (k == start + HOLD - 1) begin ph = PH_SEARCH; start = k + 1; end
         end else if (ph == PH_SEARCH) begin
            win = (k - (LSC - 1) >= start);
            for (int j = 0; j < LSC; j++) win = win & ls(k - j);
            if (k == start + TO - 1) begin
               retries++;
               ph = (retries == MR) ? PH_FAIL : PH_HOLD;
               start = k + 1;
            end else if (win) begin
               ph = PH_RUN; retries = 0;
            end
         end else if (ph == PH_RUN) begin
            if (!ls(k)) begin
               if (loss < 255) loss++;
               ph = PH_HOLD; start = k + 1;
            end
         end
      end
   endtask

   task automatic run_trace(input string name, input int len);
      logic [18:0] ov;
      build_model(len);
      @(posedge clk); #1;
      rst = 1'b1; restart_r = 1'b0; locked_r = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < len; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         locked_r  = lk[k];
         restart_r = rs[k];
         @(negedge clk);
         ob_st[k] = o_st; ob_mrst[k] = o_mrst; ob_crst[k] = o_crst;
         ob_rdy[k] = o_rdy; ob_err[k] = o_err; ob_rt[k] = o_rt; ob_ll[k] = o_ll;
         ov = {o_st, o_mrst, o_crst, o_rdy, o_err, o_rt, o_ll};
         check($sformatf("%s_c%0d", name, k), 32'(ov), 32'(pack(ex_st[k], ex_rt[k], ex_ll[k])));
      end
   endtask

   initial begin
      int d;
      int entries;
      int runs;
      int lvl;
      int seg;
      rst = 1'b1; restart_r = 1'b0; locked_r = 1'b0;

      // Clean lock at cycle 10.
      n = 40;
      for (int k = 0; k < n; k++) begin lk[k] = (k >= 10); rs[k] = 1'b0; end
      run_trace("s1", n);
      check("rst_state", 32'(ob_st[0]), 32'(ST_RST_HOLD));
      check("rst_core", 32'(ob_crst[0]), 32'd1);
      check("rst_ready", 32'(ob_rdy[0]), 32'd0);
      check("rst_error", 32'(ob_err[0]), 32'd0);
      check("rst_retry", 32'(ob_rt[0]), 32'd0);
      check("rst_loss", 32'(ob_ll[0]), 32'd0);
      for (int k = 0; k < 4; k++) check($sformatf("s1_mrst_c%0d", k), 32'(ob_mrst[k]), 32'd1);
      check("s1_mrst_c4", 32'(ob_mrst[4]), 32'd0);
      check("s1_ready_c19", 32'(ob_rdy[19]), 32'd0);
      check("s1_ready_c20", 32'(ob_rdy[20]), 32'd1);
      check("s1_core_c20", 32'(ob_crst[20]), 32'd0);

      // No lock at all: two timeouts then FAIL.
      n = 130;
      for (int k = 0; k < n; k++) begin lk[k] = 1'b0; rs[k] = 1'b0; end
      run_trace("s2", n);
      check("s2_abort_state", 32'(ob_st[0]), 32'(ST_RST_HOLD));
      check("s2_retry_c53", 32'(ob_rt[53]), 32'd0);
      check("s2_retry_c54", 32'(ob_rt[54]), 32'd1);
      check("s2_state_c54", 32'(ob_st[54]), 32'(ST_RST_HOLD));
      check("s2_state_c107", 32'(ob_st[107]), 32'(ST_WAIT_LOCK));
      check("s2_state_c108", 32'(ob_st[108]), 32'(ST_FAIL));
      check("s2_retry_c108", 32'(ob_rt[108]), 32'd2);
      check("s2_error_c108", 32'(ob_err[108]), 32'd1);
      check("s2_mrst_c129", 32'(ob_mrst[129]), 32'd1);

      // Chattering lock: high 5, low 1.
      n = 60;
      for (int k = 0; k < n; k++) begin lk[k] = ((k % 6) != 5); rs[k] = 1'b0; end
      run_trace("s3", n);
      runs = 0;
      for (int k = 0; k < n; k++) if (ob_st[k] == ST_RUN) runs++;
      check("s3_run_cycles", 32'(runs), 32'd0);
      check("s3_state_c54", 32'(ob_st[54]), 32'(ST_RST_HOLD));
      check("s3_retry_c54", 32'(ob_rt[54]), 32'd1);

      // 300 single-cycle lock drops while running.
      d = 40;
      for (int k = 0; k < MAXN; k++) begin lk[k] = (k >= 10); rs[k] = 1'b0; end
      for (int j = 0; j < 300; j++) begin
         lk[d] = 1'b0;
         d = d + 15 + int'($urandom_range(0, 5));
      end
      n = d + 20;
      run_trace("s4", n);
      entries = 0;
      for (int k = 1; k < n; k++) if (ob_st[k] == ST_RUN && ob_st[k-1] != ST_RUN) entries++;
      check("s4_run_entries", 32'(entries), 32'd301);
      check("s4_loss_sat", 32'(ob_ll[n-1]), 32'd255);
      check("s4_ready_end", 32'(ob_rdy[n-1]), 32'd1);

      // Restart from FAIL, then restart coinciding with a lock loss in RUN.
      n = 170;
      for (int k = 0; k < n; k++) begin lk[k] = (k >= 112) && (k != 140); rs[k] = 1'b0; end
      rs[115] = 1'b1;
      rs[142] = 1'b1;
      run_trace("s5", n);
      check("s5_error_c115", 32'(ob_err[115]), 32'd1);
      check("s5_state_c116", 32'(ob_st[116]), 32'(ST_RST_HOLD));
      check("s5_error_c116", 32'(ob_err[116]), 32'd0);
      check("s5_retry_c116", 32'(ob_rt[116]), 32'd0);
      check("s5_ready_c128", 32'(ob_rdy[128]), 32'd1);
      check("s5_state_c143", 32'(ob_st[143]), 32'(ST_RST_HOLD));
      check("s5_loss_c143", 32'(ob_ll[143]), 32'd1);
      check("s5_ready_c143", 32'(ob_rdy[143]), 32'd0);

      // Random lock waveforms with sporadic restarts.
      for (int r = 0; r < 4; r++) begin
         n = 400;
         lvl = int'($urandom_range(0, 1));
         seg = 0;
         for (int k = 0; k < n; k++) begin
            if (seg == 0) begin
               lvl = 1 - lvl;
               seg = int'($urandom_range(1, 30));
            end
            lk[k] = (lvl != 0);
            seg--;
            rs[k] = ($urandom_range(0, 99) == 0);
         end
         run_trace($sformatf("rnd%0d", r), n);
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
